knn_sort: RTL
=============

KNN_SORT -- requirements
Module: knn_sort

Interface
REQ-001 Parameter: DIST_WIDTH, default 34, width of one squared distance (2*16 + clog2(3)).
REQ-002 Parameter: IDX_WIDTH, default 16, width of the candidate point index.
REQ-003 Parameter: K, default 8, number of nearest neighbours kept (legal range 2..32).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_vld  input  1  candidate present on in_dist/in_idx/in_last.
REQ-007 in_rdy  output  1  block accepts a candidate this cycle.
REQ-008 in_dist  input  DIST_WIDTH  squared distance from the distance calculator.
REQ-009 in_idx  input  IDX_WIDTH  index of the candidate point.
REQ-010 in_last  input  1  final candidate for the current centre point.
REQ-011 out_vld  output  1  sorted neighbour list available.
REQ-012 out_rdy  input  1  consumer takes the list.
REQ-013 out_dist  output  K*DIST_WIDTH  sorted distances; slot 0 holds the smallest.
REQ-014 out_idx  output  K*IDX_WIDTH  indices matching out_dist slot for slot.
REQ-015 out_cnt  output  clog2(K+1)  number of valid slots, 0..K.

Function
REQ-016 FSM SHALL have exactly two states: COLLECT (reset state) and DRAIN.
REQ-017 In COLLECT, in_rdy SHALL be 1 and out_vld 0; in DRAIN, in_rdy SHALL be 0 and out_vld 1.
REQ-018 A candidate is accepted when in_vld and in_rdy are both 1; acceptance SHALL insert it into the list in the same clock edge (one candidate per cycle, no bubbles).
REQ-019 Insertion SHALL be a parallel compare-and-shift: slot j takes the new entry if new < slot j and new >= slot j-1, takes slot j-1 if new < slot j-1, else holds.
REQ-020 Ties SHALL be stable: a new candidate equal to an existing distance is placed after it.
REQ-021 Empty slots SHALL compare as larger than any distance (per-slot valid bit, not a max-value sentinel).
REQ-022 When out_cnt == K and in_dist >= slot K-1, the candidate SHALL be discarded and the list left unchanged.
REQ-023 out_cnt SHALL increment on each inserted candidate and saturate at K.
REQ-024 Accepting a candidate with in_last = 1 SHALL move the FSM to DRAIN on that same edge; out_vld SHALL be 1 the following cycle (latency 1).
REQ-025 In DRAIN, out_dist/out_idx/out_cnt SHALL hold stable until out_vld and out_rdy are both 1.
REQ-026 On the DRAIN handshake, all slots SHALL be invalidated, out_cnt cleared and the FSM returned to COLLECT; in_rdy SHALL be 1 in the next cycle.
REQ-027 out_dist/out_idx slots at or above out_cnt SHALL read as 0.
REQ-028 Distances SHALL be compared as unsigned DIST_WIDTH values; no truncation.

Reset
REQ-029 When rst is 1 at a clock edge: FSM -> COLLECT, all slot valid bits -> 0, out_cnt -> 0, out_vld -> 0, in_rdy -> 1 in the next cycle, out_dist/out_idx -> 0.
REQ-030 Reset mid-collection or mid-drain SHALL discard the partial list with no output handshake.

Structure
REQ-031 DIST_WIDTH, IDX_WIDTH, K and the FSM state encoding SHALL live in the shared map package used by the distance calculator.
REQ-032 One sub-module knn_slot SHALL implement a single slot's compare/shift/valid cell; knn_sort SHALL instantiate K of them plus the FSM and counter.

Verification
REQ-033 Reset, then stream distances 50,10,30 (idx 0,1,2), last on idx 2 -> out_cnt=3, out_dist=10,30,50, out_idx=1,2,0, out_vld 1 cycle after last.
REQ-034 K=8, stream 12 candidates with distances 12 down to 1 -> out_dist=1..8 ascending, out_cnt=8.
REQ-035 Full list with slot 7 = 20, send distance 20 then 25 -> both discarded, list unchanged.
REQ-036 Tie: distances 5 (idx 3) then 5 (idx 9) -> slot 0 idx 3, slot 1 idx 9.
REQ-037 Hold out_rdy=0 for 5 cycles in DRAIN with in_vld=1 -> in_rdy=0, outputs stable, no candidate accepted; then out_rdy=1 -> COLLECT, out_cnt=0 next cycle.
REQ-038 Assert rst after 4 of 6 candidates -> out_vld stays 0, next centre's list contains only post-reset candidates.

Source files
------------

// File: rtl/knn_sort_pkg.sv
// Shared map definitions for the k-nearest-neighbour pipeline: default widths,
// neighbour count and the sorter FSM encoding.
package knn_sort_pkg;

  localparam int DIST_WIDTH_DEF = 34;
  localparam int IDX_WIDTH_DEF  = 16;
  localparam int K_DEF          = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

endpackage

// File: rtl/knn_slot.sv
// One cell of the insertion-sorted neighbour list. The cell either holds its
// entry, takes the new candidate, or takes the entry shifted from the cell before it.
module knn_slot
  import knn_sort_pkg::*;
#(
  parameter int DIST_WIDTH = DIST_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  ins_i,
  input  logic [DIST_WIDTH-1:0] new_dist_i,
  input  logic [IDX_WIDTH-1:0]  new_idx_i,
  input  logic                  prev_lt_i,
  input  logic                  prev_vld_i,
  input  logic [DIST_WIDTH-1:0] prev_dist_i,
  input  logic [IDX_WIDTH-1:0]  prev_idx_i,
  output logic                  lt_o,
  output logic                  vld_o,
  output logic [DIST_WIDTH-1:0] dist_o,
  output logic [IDX_WIDTH-1:0]  idx_o
);

  logic                  vld_q, vld_d;
  logic [DIST_WIDTH-1:0] dist_q, dist_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  take;

  // Strict less-than keeps equal distances in arrival order; an empty cell
  // always loses to the candidate.
  assign lt_o = !vld_q || (new_dist_i < dist_q);
  assign take = ins_i && lt_o;

  always_comb begin
    vld_d  = vld_q;
    dist_d = dist_q;
    idx_d  = idx_q;
    if (take) begin
      if (prev_lt_i) begin
        vld_d  = prev_vld_i;
        dist_d = prev_dist_i;
        idx_d  = prev_idx_i;
      end else begin
        vld_d  = 1'b1;
        dist_d = new_dist_i;
        idx_d  = new_idx_i;
      end
    end
    if (clr_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    dist_q <= dist_d;
    idx_q  <= idx_d;
  end

  assign vld_o  = vld_q;
  assign dist_o = dist_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/knn_sort.sv
// Keeps the K smallest squared distances for one centre point, sorted ascending,
// and presents the list once the last candidate has been accepted.
module knn_sort
  import knn_sort_pkg::*;
#(
  parameter int DIST_WIDTH = DIST_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
  parameter int K          = K_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DIST_WIDTH-1:0]   in_dist,
  input  logic [IDX_WIDTH-1:0]    in_idx,
  input  logic                    in_last,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [K*DIST_WIDTH-1:0] out_dist,
  output logic [K*IDX_WIDTH-1:0]  out_idx,
  output logic [$clog2(K+1)-1:0]  out_cnt
);

  localparam int CNT_W = $clog2(K+1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(K)) ? c : c + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             drain_done;
  logic             inserted;

  logic                  slot_lt   [K];
  logic                  slot_vld  [K];
  logic [DIST_WIDTH-1:0] slot_dist [K];
  logic [IDX_WIDTH-1:0]  slot_idx  [K];

  assign in_rdy     = (state_q == COLLECT);
  assign out_vld    = (state_q == DRAIN);
  assign accept     = in_vld && in_rdy;
  assign drain_done = out_vld && out_rdy;
  // The list is sorted, so the last cell wants the candidate whenever any cell does.
  assign inserted   = accept && slot_lt[K-1];

  for (genvar j = 0; j < K; j++) begin : g_slot
    if (j == 0) begin : g_head
      knn_slot #(
        .DIST_WIDTH(DIST_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (drain_done),
        .ins_i      (accept),
        .new_dist_i (in_dist),
        .new_idx_i  (in_idx),
        .prev_lt_i  (1'b0),
        .prev_vld_i (1'b0),
        .prev_dist_i('0),
        .prev_idx_i ('0),
        .lt_o       (slot_lt[j]),
        .vld_o      (slot_vld[j]),
        .dist_o     (slot_dist[j]),
        .idx_o      (slot_idx[j])
      );
    end else begin : g_tail
      knn_slot #(
        .DIST_WIDTH(DIST_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (drain_done),
        .ins_i      (accept),
        .new_dist_i (in_dist),
        .new_idx_i  (in_idx),
        .prev_lt_i  (slot_lt[j-1]),
        .prev_vld_i (slot_vld[j-1]),
        .prev_dist_i(slot_dist[j-1]),
        .prev_idx_i (slot_idx[j-1]),
        .lt_o       (slot_lt[j]),
        .vld_o      (slot_vld[j]),
        .dist_o     (slot_dist[j]),
        .idx_o      (slot_idx[j])
      );
    end
    assign out_dist[j*DIST_WIDTH +: DIST_WIDTH] = slot_vld[j] ? slot_dist[j] : '0;
    assign out_idx[j*IDX_WIDTH +: IDX_WIDTH]    = slot_vld[j] ? slot_idx[j]  : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT: begin
        if (inserted) begin
          cnt_d = sat_inc(cnt_q);
        end
        if (accept && in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_rdy) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;

endmodule
